// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Purpose  : IF stage of the 5-stage RV32I pipeline. Owns the PC, addresses
//            the combinational instruction memory and fills the IF/ID
//            register. Handles hazard stalls and EX redirects. A fetched
//            all-zero word ends the run: fetch stops, the pipeline drains for
//            DRAIN_CYCLES bubbles and a sticky halt is raised.
// Revision : 1.0  initial release
// ============================================================================
module fetch_stage #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          DRAIN_CYCLES = 4,
    parameter logic [31:0] NOP          = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_instr_i,
    output logic        ifid_valid_o,
    output logic [31:0] ifid_pc_o,
    output logic [31:0] ifid_instr_o,
    output logic [31:0] ifid_pc4_o,
    output logic        halt_o
);

    localparam int          c_cnt_w    = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DRAIN_CYCLES - 1);
    localparam logic [31:0] c_reset_pc = {RESET_PC[31:2], 2'b00};

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_DRAIN = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [c_cnt_w-1:0] r_cnt,   w_cnt_nxt;
    logic [31:0]        r_pc,    w_pc_nxt;
    logic               r_ifid_valid, w_ifid_valid_nxt;
    logic [31:0]        r_ifid_pc,    w_ifid_pc_nxt;
    logic [31:0]        r_ifid_instr, w_ifid_instr_nxt;
    logic [31:0]        r_ifid_pc4,   w_ifid_pc4_nxt;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_redirect_pc;
    logic        w_unused_redirect_lsbs;

    // Targets are forced word-aligned; the dropped low bits are deliberately ignored.
    assign w_redirect_pc          = {redirect_pc_i[31:2], 2'b00};
    assign w_unused_redirect_lsbs = ^redirect_pc_i[1:0];
    assign w_pc_plus4             = r_pc + 32'd4;

    assign imem_addr_o  = r_pc;
    assign ifid_valid_o = r_ifid_valid;
    assign ifid_pc_o    = r_ifid_pc;
    assign ifid_instr_o = r_ifid_instr;
    assign ifid_pc4_o   = r_ifid_pc4;
    assign halt_o       = (r_state == S_HALT);

    // State, counter, PC and IF/ID register update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_RUN;
            r_cnt        <= '0;
            r_pc         <= c_reset_pc;
            r_ifid_valid <= 1'b0;
            r_ifid_pc    <= 32'h0;
            r_ifid_instr <= NOP;
            r_ifid_pc4   <= 32'h0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_pc         <= w_pc_nxt;
            r_ifid_valid <= w_ifid_valid_nxt;
            r_ifid_pc    <= w_ifid_pc_nxt;
            r_ifid_instr <= w_ifid_instr_nxt;
            r_ifid_pc4   <= w_ifid_pc4_nxt;
        end
    end

    // Next-state logic; priority per edge is redirect, then stall, then normal flow.
    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_pc_nxt         = r_pc;
        w_ifid_valid_nxt = r_ifid_valid;
        w_ifid_pc_nxt    = r_ifid_pc;
        w_ifid_instr_nxt = r_ifid_instr;
        w_ifid_pc4_nxt   = r_ifid_pc4;

        case (r_state)
            S_HALT: begin
                // Frozen until reset; redirect and stall have no effect.
                w_ifid_valid_nxt = 1'b0;
                w_ifid_instr_nxt = NOP;
            end

            S_DRAIN: begin
                w_ifid_valid_nxt = 1'b0;
                w_ifid_instr_nxt = NOP;
                if (redirect_i) begin
                    // The zero word was on the wrong path: resume fetching.
                    w_pc_nxt    = w_redirect_pc;
                    w_state_nxt = S_RUN;
                    w_cnt_nxt   = '0;
                end else if (stall_i) begin
                    w_cnt_nxt = r_cnt;
                end else if (r_cnt == c_cnt_last) begin
                    w_state_nxt = S_HALT;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end

            default: begin
                // S_RUN, and any unencoded state recovers as S_RUN.
                w_state_nxt = S_RUN;
                if (redirect_i) begin
                    w_pc_nxt         = w_redirect_pc;
                    w_ifid_valid_nxt = 1'b0;
                    w_ifid_instr_nxt = NOP;
                end else if (stall_i) begin
                    w_pc_nxt = r_pc;
                end else if (imem_instr_i == 32'h0) begin
                    w_ifid_valid_nxt = 1'b0;
                    w_ifid_instr_nxt = NOP;
                    w_state_nxt      = S_DRAIN;
                    w_cnt_nxt        = '0;
                end else begin
                    w_pc_nxt         = w_pc_plus4;
                    w_ifid_valid_nxt = 1'b1;
                    w_ifid_pc_nxt    = r_pc;
                    w_ifid_instr_nxt = imem_instr_i;
                    w_ifid_pc4_nxt   = w_pc_plus4;
                end
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_stage
// Purpose  : Directed self-checking bench for fetch_stage with a small
//            combinational instruction memory model.
// Revision : 1.0  initial release
// ============================================================================
module tb_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_instr_i;
    logic        ifid_valid_o;
    logic [31:0] ifid_pc_o;
    logic [31:0] ifid_instr_o;
    logic [31:0] ifid_pc4_o;
    logic        halt_o;

    int total = 0;
    int bad   = 0;

    logic [31:0] mem [0:63];

    fetch_stage #(
        .RESET_PC     (32'h0000_0000),
        .DRAIN_CYCLES (4),
        .NOP          (32'h0000_0013)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_addr_o   (imem_addr_o),
        .imem_instr_i  (imem_instr_i),
        .ifid_valid_o  (ifid_valid_o),
        .ifid_pc_o     (ifid_pc_o),
        .ifid_instr_o  (ifid_instr_o),
        .ifid_pc4_o    (ifid_pc4_o),
        .halt_o        (halt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational instruction memory, 64 words aliased over the address space.
    assign imem_instr_i = mem[imem_addr_o[7:2]];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%08h expected=%08h", tag, got, exp);
        end
    endtask

    // One rising edge, then settle to the falling edge for sampling.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_ifid(input string tag, input logic v, input logic [31:0] pc,
                            input logic [31:0] ins, input logic [31:0] pc4);
        chk({tag, "_valid"}, {31'h0, ifid_valid_o}, {31'h0, v});
        chk({tag, "_pc"},    ifid_pc_o,    pc);
        chk({tag, "_instr"}, ifid_instr_o, ins);
        chk({tag, "_pc4"},   ifid_pc4_o,   pc4);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0000_0013;
        mem[0]  = 32'h0050_0093;
        mem[1]  = 32'h0010_0113;
        mem[2]  = 32'h0020_81B3;
        mem[3]  = 32'h0000_0033;
        mem[4]  = 32'h0000_0000;   // zero word at 0x10 ends the run
        mem[16] = 32'h0040_0213;   // 0x40
        mem[63] = 32'h1234_5013;   // 0xFFFFFFFC aliases here

        rst_n = 1'b0; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0;

        // Reset state.
        repeat (2) @(negedge clk);
        chk("rst_addr", imem_addr_o, 32'h0);
        chk_ifid("rst", 1'b0, 32'h0, 32'h13, 32'h0);
        chk("rst_halt", {31'h0, halt_o}, 32'h0);
        rst_n = 1'b1;

        // Sequential fetch.
        step(); chk_ifid("seq0", 1'b1, 32'h0, 32'h0050_0093, 32'h4);
        chk("seq0_addr", imem_addr_o, 32'h4);
        step(); chk_ifid("seq1", 1'b1, 32'h4, 32'h0010_0113, 32'h8);
        chk("seq1_addr", imem_addr_o, 32'h8);

        // Two-cycle stall at pc=8.
        stall_i = 1'b1;
        step(); chk("stall1_addr", imem_addr_o, 32'h8);
        chk_ifid("stall1", 1'b1, 32'h4, 32'h0010_0113, 32'h8);
        step(); chk("stall2_addr", imem_addr_o, 32'h8);
        chk_ifid("stall2", 1'b1, 32'h4, 32'h0010_0113, 32'h8);
        stall_i = 1'b0;
        step(); chk_ifid("resume", 1'b1, 32'h8, 32'h0020_81B3, 32'hC);
        chk("resume_addr", imem_addr_o, 32'hC);

        // Redirect wins over stall; target low bits dropped.
        stall_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h43;
        step(); chk("redir_addr", imem_addr_o, 32'h40);
        chk_ifid("redir", 1'b0, 32'h8, 32'h13, 32'hC);
        stall_i = 1'b0; redirect_i = 1'b0;
        step(); chk_ifid("redir_tgt", 1'b1, 32'h40, 32'h0040_0213, 32'h44);
        chk("redir_tgt_addr", imem_addr_o, 32'h44);

        // Drain and halt: jump to the zero word at 0x10.
        redirect_i = 1'b1; redirect_pc_i = 32'h10;
        step(); redirect_i = 1'b0;
        chk("pre_zero_addr", imem_addr_o, 32'h10);
        step();   // detect edge
        chk("detect_addr", imem_addr_o, 32'h10);
        chk("detect_valid", {31'h0, ifid_valid_o}, 32'h0);
        chk("detect_instr", ifid_instr_o, 32'h13);
        chk("detect_halt", {31'h0, halt_o}, 32'h0);
        for (int k = 1; k <= 3; k++) begin
            step();
            chk($sformatf("drain%0d_halt", k), {31'h0, halt_o}, 32'h0);
            chk($sformatf("drain%0d_addr", k), imem_addr_o, 32'h10);
        end
        step(); chk("halt_rise", {31'h0, halt_o}, 32'h1);
        chk("halt_addr", imem_addr_o, 32'h10);
        redirect_i = 1'b1; stall_i = 1'b1; redirect_pc_i = 32'h40;
        step(); chk("halt_sticky", {31'h0, halt_o}, 32'h1);
        chk("halt_frozen_addr", imem_addr_o, 32'h10);
        chk("halt_valid", {31'h0, ifid_valid_o}, 32'h0);
        redirect_i = 1'b0; stall_i = 1'b0;

        // Asynchronous reset from HALT.
        #2 rst_n = 1'b0;
        #1;
        chk("areset_halt", {31'h0, halt_o}, 32'h0);
        chk("areset_addr", imem_addr_o, 32'h0);
        chk("areset_instr", ifid_instr_o, 32'h13);
        @(negedge clk); rst_n = 1'b1;

        // Wrong-path zero word: redirect on the 2nd DRAIN cycle.
        repeat (4) step();                 // fetch 0x0..0xC
        chk("run2_addr", imem_addr_o, 32'h10);
        step();                            // detect edge
        step();                            // first drain cycle
        redirect_i = 1'b1; redirect_pc_i = 32'h20;
        step(); redirect_i = 1'b0;
        chk("wp_addr", imem_addr_o, 32'h20);
        chk("wp_valid", {31'h0, ifid_valid_o}, 32'h0);
        step(); chk_ifid("wp_fetch", 1'b1, 32'h20, 32'h13, 32'h24);
        repeat (4) step();
        chk("wp_run_addr", imem_addr_o, 32'h34);
        chk("wp_no_halt", {31'h0, halt_o}, 32'h0);

        // PC wrap at the top of the address space.
        redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC;
        step(); redirect_i = 1'b0;
        chk("wrap_top_addr", imem_addr_o, 32'hFFFF_FFFC);
        step(); chk("wrap_addr", imem_addr_o, 32'h0);
        chk_ifid("wrap", 1'b1, 32'hFFFF_FFFC, 32'h1234_5013, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
